muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide engine and pipeline interlock for the pipelined CPU EX stage.
//  - Accepts one MULT/MULTU/DIV/DIVU from EX and runs one shift-add or restoring-subtract step per cycle.
//  - Holds the 64-bit result in HI/LO.
//  - Raises a stall to the hazard logic when a new mul/div op or an mfhi/mflo read is presented while it is busy.

---
 rtl/cpu_defs.sv | 18 +
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_sequencer.sv | 152 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared EX-stage definitions: mul/div op codes and sequencer state encodings.
package cpu_defs;

  // bit1 selects divide, bit0 selects signed operation
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the mul/div engine: shift-add multiply or
// restoring trial-subtract divide on the {acc, shreg} register pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] trial;

  assign sum   = {1'b0, acc} + {1'b0, operand};
  assign rem   = {acc, shreg[WIDTH-1]};
  assign trial = rem - {1'b0, operand};

  // NOTE: every output gets a default before the branches, so no latch is inferred.
  always_comb begin
    acc_next   = acc;
    shreg_next = shreg;
    if (is_div) begin
      // Partial remainder < divisor, so a clear top bit means the subtract fits.
      if (!trial[WIDTH]) begin
        acc_next   = trial[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next   = rem[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
      end
    end else if (shreg[0]) begin
      {acc_next, shreg_next} = {sum, shreg[WIDTH-1:1]};
    end else begin
      {acc_next, shreg_next} = {1'b0, acc, shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer with HI/LO result registers and the
// EX-stage interlock that stalls new mul/div ops and HI/LO reads while busy.
module muldiv_sequencer
  import cpu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] acc_q, acc_d, shreg_q, shreg_d, operand_q, operand_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             is_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] acc_step, shreg_step;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_signed = op[0];
  assign abs_a = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_q),
    .shreg     (shreg_q),
    .operand   (operand_q),
    .is_div    (is_div_q),
    .acc_next  (acc_step),
    .shreg_next(shreg_step)
  );

  // min / -1 needs no special case: negating the magnitude quotient wraps back to min.
  assign prod_fix = neg_res_q ? -{acc_step, shreg_step} : {acc_step, shreg_step};
  assign quo_fix  = neg_res_q ? -shreg_step : shreg_step;
  assign rem_fix  = neg_rem_q ? -acc_step : acc_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    operand_d = operand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = 1'b0;

    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (state_q == MD_DONE) state_d = MD_IDLE;
        if (start && !flush) begin
          is_div_d  = op[1];
          neg_res_d = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_rem_d = is_signed & src_a[WIDTH-1];
          cnt_d     = '0;
          if (op[1] && (src_b == '0)) begin
            state_d = MD_DONE;
            hi_d    = src_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d   = MD_RUN;
            acc_d     = '0;
            shreg_d   = abs_a;
            operand_d = abs_b;
          end
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d   = acc_step;
          shreg_d = shreg_step;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = MD_DONE;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      acc_q     <= '0;
      shreg_q   <= '0;
      operand_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      operand_q <= operand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != MD_IDLE);
  assign stall       = (state_q == MD_RUN) && (start || rd_hilo);
  assign done        = (state_q == MD_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO and
// done cycle; a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
  import cpu_defs::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src_a, src_b;
  logic             rd_hilo, flush;
  logic             busy, stall, done, div_by_zero;
  logic [WIDTH-1:0] hi, lo;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op_i),
    .src_a      (src_a),
    .src_b      (src_b),
    .rd_hilo    (rd_hilo),
    .flush      (flush),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_by_zero", div_by_zero, e.dbz);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic present(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    op_i  = op;
    src_a = a;
    src_b = b;
  endtask

  // Called at the negedge where start is presented; edge k is the next posedge.
  task automatic expect_result(input logic [WIDTH-1:0] e_hi, input logic [WIDTH-1:0] e_lo, input logic e_dbz);
    exp_t e;
    e.hi  = e_hi;
    e.lo  = e_lo;
    e.dbz = e_dbz;
    e.cyc = cyc + 1 + (e_dbz ? 0 : WIDTH);
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] e_hi, input logic [WIDTH-1:0] e_lo, input logic e_dbz);
    @(negedge clk);
    present(op, a, b);
    expect_result(e_hi, e_lo, e_dbz);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; op_i = 2'b00; src_a = '0; src_b = '0;
    rd_hilo = 1'b0; flush = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;

    // Arithmetic vectors, hand-computed
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(MD_MULT,  -32'sd7, 32'sd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
    run_op(MD_DIV,   -32'sd7, 32'sd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(MD_DIV,   32'sd7, -32'sd2, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op(MD_DIV,   -32'sd7, -32'sd2, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    run_op(MD_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op(MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // Interlock: rd_hilo from cycle k+5, stray start at k+10 (must not be captured)
    @(negedge clk);
    present(MD_MULTU, 32'd3, 32'd5);
    expect_result(32'd0, 32'd15, 1'b0);
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int n = k + 1; n <= k + 33; n++) begin
      if (n != k + 1) @(negedge clk);
      rd_hilo = (n >= k + 5);
      if (n == k + 10) present(MD_DIVU, 32'd9, 32'd3);
      else start = 1'b0;
      #1;
      check($sformatf("stall_c%0d", n - k), stall, (n >= k + 5) && (n <= k + 32));
    end
    @(negedge clk);
    rd_hilo = 1'b0;
    wait_drain();
    check("stall_idle_busy", busy, 0);

    // Reference result for the abort tests
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // Flush at cycle k+10 of a DIVU: idle at k+11, no done, HI/LO kept
    @(negedge clk);
    present(MD_DIVU, 32'd1000, 32'd3);
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_cycle", cyc, k + 10);
    check("flush_busy_after", busy, 0);
    check("flush_hi", hi, 32'd2);
    check("flush_lo", lo, 32'd14);
    repeat (40) @(negedge clk);
    check("flush_no_done", done, 0);

    // Flush with start in IDLE: start ignored
    @(negedge clk);
    present(MD_MULTU, 32'd4, 32'd4);
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_idle_busy", busy, 0);
    check("flush_idle_lo", lo, 32'd14);

    // Reset at cycle k+10 of a DIVU: everything cleared
    @(negedge clk);
    present(MD_DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_hi", hi, 0);
    check("mrst_lo", lo, 0);
    check("mrst_done", done, 0);
    reset = 1'b0;

    // Back-to-back: second op presented in the DONE cycle of the first
    @(negedge clk);
    present(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    expect_result(32'd1, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b_first_done", done, 1);
    present(MD_DIVU, 32'd1000, 32'd3);
    expect_result(32'd1, 32'd333, 1'b0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("b2b_rerun_busy", busy, 1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
